// File: rtl/vgahdmi_fetch_ctrl.sv
// vgahdmi_fetch_ctrl: fetches frame-buffer words into a show-ahead FIFO for the bit-plane video output.
// One memory read is in flight at most; a vsync rise during a read flushes that read before restarting.
module vgahdmi_fetch_ctrl #(
    parameter int resolution_x    = 640,
    parameter int resolution_y    = 480,
    parameter int words_per_frame = resolution_x * resolution_y / 8,
    parameter int fifo_depth_log2 = 4,
    parameter int addr_width      = 30
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [addr_width-1:0] base_addr,
    input  logic                  vsync,
    input  logic                  fetch_next,
    output logic [7:0]            red_byte,
    output logic [7:0]            green_byte,
    output logic [7:0]            blue_byte,
    output logic [7:0]            bright_byte,
    output logic [addr_width-1:0] mem_addr,
    output logic                  mem_addr_strobe,
    input  logic [31:0]           mem_data_in,
    input  logic                  mem_data_ready,
    output logic                  underflow,
    output logic                  frame_done
);
    localparam int DEPTH = 1 << fifo_depth_log2;
    localparam int CW    = fifo_depth_log2 + 1;
    localparam int RW    = $clog2(words_per_frame + 1);

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t                     state_q;
    logic                       vsync_q;
    logic [31:0]                fifo_q [DEPTH];
    logic [fifo_depth_log2-1:0] wptr_q, rptr_q;
    logic [CW-1:0]              count_q, count_d;
    logic [addr_width-1:0]      addr_q, base_q;
    logic [RW-1:0]              remaining_q;
    logic                       strobe_q, underflow_q, done_q;
    logic                       rise, ack, push, pop;

    assign rise    = vsync & ~vsync_q;
    assign ack     = strobe_q & mem_data_ready;
    assign push    = ack & (state_q == FETCH) & ~rise;
    assign pop     = fetch_next & ~rise & (count_q != '0);
    assign count_d = count_q + CW'(push) - CW'(pop);

    assign {bright_byte, blue_byte, green_byte, red_byte} = (count_q != '0) ? fifo_q[rptr_q] : 32'h0;
    assign mem_addr        = addr_q;
    assign mem_addr_strobe = strobe_q;
    assign underflow       = underflow_q;
    assign frame_done      = done_q;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            base_q      <= '0;
            remaining_q <= '0;
            strobe_q    <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            vsync_q <= vsync;
            if (fetch_next && !rise && count_q == '0)
                underflow_q <= 1'b1;
            if (rise) begin
                base_q      <= base_addr;
                remaining_q <= RW'(words_per_frame);
                count_q     <= '0;
                wptr_q      <= '0;
                rptr_q      <= '0;
                done_q      <= 1'b0;
                // A read still waiting for its ack must finish before the new frame starts
                if (strobe_q && !mem_data_ready) begin
                    state_q <= FLUSH;
                end else begin
                    state_q  <= FETCH;
                    addr_q   <= base_addr;
                    strobe_q <= 1'b1;
                end
            end else begin
                count_q <= count_d;
                if (push) begin
                    fifo_q[wptr_q] <= mem_data_in;
                    wptr_q         <= wptr_q + fifo_depth_log2'(1);
                end
                if (pop)
                    rptr_q <= rptr_q + fifo_depth_log2'(1);
                if (state_q == FLUSH) begin
                    if (mem_data_ready) begin
                        state_q  <= FETCH;
                        addr_q   <= base_q;
                        strobe_q <= 1'b1;
                    end
                end else if (state_q == FETCH && (ack || !strobe_q)) begin
                    if (ack) begin
                        addr_q      <= addr_q + addr_width'(1);
                        remaining_q <= remaining_q - RW'(1);
                    end
                    // count_d already includes this cycle's push, so a new request reserves a free slot
                    if (ack && remaining_q == RW'(1)) begin
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                        strobe_q <= 1'b0;
                    end else begin
                        strobe_q <= ~count_d[fifo_depth_log2];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vgahdmi_fetch_ctrl.sv
// tb_vgahdmi_fetch_ctrl: queue-based reference model checked every cycle, plus directed
// frame, flush, underflow and FIFO-wrap scenarios with hand-computed expectations.
module tb_vgahdmi_fetch_ctrl;
    localparam int WPF = 120;
    localparam int AW  = 30;

    logic          clk = 1'b0;
    logic          reset, vsync, fetch_next;
    logic          mem_addr_strobe, mem_data_ready, underflow, frame_done;
    logic [AW-1:0] base_addr, mem_addr;
    logic [31:0]   mem_data_in;
    logic [7:0]    red_byte, green_byte, blue_byte, bright_byte;

    int n_chk = 0, n_fail = 0;
    int ack_delay = 0, budget = 0, acks = 0, wait_cnt = 0;

    vgahdmi_fetch_ctrl #(.words_per_frame(WPF)) dut (
        .clk_pixel      (clk),
        .reset          (reset),
        .base_addr      (base_addr),
        .vsync          (vsync),
        .fetch_next     (fetch_next),
        .red_byte       (red_byte),
        .green_byte     (green_byte),
        .blue_byte      (blue_byte),
        .bright_byte    (bright_byte),
        .mem_addr       (mem_addr),
        .mem_addr_strobe(mem_addr_strobe),
        .mem_data_in    (mem_data_in),
        .mem_data_ready (mem_data_ready),
        .underflow      (underflow),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 50) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] head();
        return {bright_byte, blue_byte, green_byte, red_byte};
    endfunction

    // Memory: acks after ack_delay waiting cycles, data = word address, at most budget acks
    initial begin
        mem_data_ready = 1'b0;
        mem_data_in    = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_data_ready) begin
                wait_cnt = 0;
                acks++;
                if (budget > 0) budget--;
            end
            mem_data_ready = 1'b0;
            if (mem_addr_strobe && budget > 0) begin
                if (wait_cnt >= ack_delay) begin
                    mem_data_ready = 1'b1;
                    mem_data_in    = 32'(mem_addr);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Reference model: FIFO contents as a queue, request stream as next address / remaining words
    logic [31:0]   m_q[$];
    logic          m_vs = 1'b0, m_strobe = 1'b0, m_under = 1'b0, m_done = 1'b0;
    logic [AW-1:0] m_addr = '0, m_base = '0;
    int            m_rem = 0, m_mode = 0;
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_vs = 1'b0; m_strobe = 1'b0; m_under = 1'b0; m_done = 1'b0;
            m_addr = '0; m_base = '0; m_rem = 0; m_mode = 0;
        end else if (vsync && !m_vs) begin
            m_vs = 1'b1;
            m_q.delete();
            m_done = 1'b0;
            m_base = base_addr;
            m_rem  = WPF;
            if (m_strobe && !mem_data_ready) begin
                m_mode = 2;
            end else begin
                m_mode = 1; m_addr = base_addr; m_strobe = 1'b1;
            end
        end else begin
            m_vs = vsync;
            if (fetch_next) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_under = 1'b1;
            end
            if (m_mode == 2) begin
                if (mem_data_ready) begin
                    m_mode = 1; m_addr = m_base; m_strobe = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (m_strobe && mem_data_ready) begin
                    m_q.push_back(mem_data_in);
                    m_addr++;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1'b1; m_mode = 0; m_strobe = 1'b0;
                    end else begin
                        m_strobe = m_q.size() < 16;
                    end
                end else if (!m_strobe) begin
                    m_strobe = m_q.size() < 16;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("model_bytes", head(), m_q.size() > 0 ? m_q[0] : 32'h0);
            chk("model_strobe", 32'(mem_addr_strobe), 32'(m_strobe));
            if (m_strobe) chk("model_addr", 32'(mem_addr), 32'(m_addr));
            chk("model_underflow", 32'(underflow), 32'(m_under));
            chk("model_frame_done", 32'(frame_done), 32'(m_done));
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_vsync(logic [AW-1:0] base);
        base_addr = base;
        vsync     = 1'b1;
        step();
        vsync     = 1'b0;
    endtask

    task automatic pop_chk(string name, logic [31:0] exp);
        fetch_next = 1'b1;
        @(negedge clk);
        chk(name, head(), exp);
        step();
        fetch_next = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; vsync = 1'b0; fetch_next = 1'b0; base_addr = '0; budget = 1 << 30;
        step(3);
        @(negedge clk);
        chk("rst_bytes", head(), 32'h0);
        chk("rst_strobe", 32'(mem_addr_strobe), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        step();
        reset = 1'b0;
        step(2);
        // Frame at 0x100, memory acking every cycle
        acks = 0;
        base_addr = 30'h100;
        vsync = 1'b1;
        @(negedge clk);
        chk("strobe_in_rise_cycle", 32'(mem_addr_strobe), 32'h0);
        step();
        vsync = 1'b0;
        @(negedge clk);
        chk("first_strobe", 32'(mem_addr_strobe), 32'h1);
        chk("first_addr", 32'(mem_addr), 32'h100);
        step(30);
        chk("full_strobe_off", 32'(mem_addr_strobe), 32'h0);
        chk("full_acks", 32'(acks), 32'd16);
        chk("head_red", 32'(red_byte), 32'h00);
        chk("head_green", 32'(green_byte), 32'h01);
        chk("head_bright", 32'(bright_byte), 32'h00);
        for (int k = 0; k < 104; k++) begin
            pop_chk("pop_order", 32'h100 + k);
            step(7);
        end
        step(5);
        chk("frame_done_set", 32'(frame_done), 32'h1);
        chk("frame_acks", 32'(acks), 32'(WPF));
        chk("done_no_underflow", 32'(underflow), 32'h0);
        step(10);
        chk("done_strobe_idle", 32'(mem_addr_strobe), 32'h0);
        for (int k = 104; k < 120; k++) begin
            pop_chk("drain_order", 32'h100 + k);
            step(2);
        end
        @(negedge clk);
        chk("drained_bytes", head(), 32'h0);
        chk("drained_no_underflow", 32'(underflow), 32'h0);
        step();
        fetch_next = 1'b1;
        step();
        fetch_next = 1'b0;
        @(negedge clk);
        chk("underflow_set", 32'(underflow), 32'h1);
        chk("underflow_bytes", head(), 32'h0);
        step();
        // Slow memory: second rise lands while the read of 0x200 is waiting
        ack_delay = 3;
        pulse_vsync(30'h200);
        @(negedge clk);
        chk("done_cleared_on_rise", 32'(frame_done), 32'h0);
        chk("underflow_sticky", 32'(underflow), 32'h1);
        chk("slow_strobe", 32'(mem_addr_strobe), 32'h1);
        chk("slow_addr", 32'(mem_addr), 32'h200);
        step();
        pulse_vsync(30'h300);
        @(negedge clk);
        chk("flush_strobe_held", 32'(mem_addr_strobe), 32'h1);
        chk("flush_addr_held", 32'(mem_addr), 32'h200);
        for (int i = 0; i < 20 && mem_addr == 30'h200; i++) @(negedge clk);
        chk("restart_addr", 32'(mem_addr), 32'h300);
        chk("restart_strobe", 32'(mem_addr_strobe), 32'h1);
        step(8);
        chk("restart_head", head(), 32'h300);
        // Reset clears underflow; push and pop together across the pointer wrap
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step();
        @(negedge clk);
        chk("underflow_cleared", 32'(underflow), 32'h0);
        step();
        ack_delay = 0;
        budget = 13;
        acks = 0;
        pulse_vsync(30'h400);
        for (int i = 0; i < 100 && acks < 13; i++) step();
        chk("wrap_fill_acks", 32'(acks), 32'd13);
        for (int k = 0; k < 8; k++) begin
            pop_chk("wrap_pop", 32'h400 + k);
            step();
        end
        budget = 5;
        fetch_next = 1'b1;
        step(5);
        fetch_next = 1'b0;
        @(negedge clk);
        chk("dual_acks", 32'(acks), 32'd18);
        chk("dual_head", head(), 32'h40D);
        step();
        pop_chk("after_dual_0", 32'h40D);
        step();
        pop_chk("after_dual_1", 32'h40E);
        step();
        pulse_vsync(30'h500);
        @(negedge clk);
        chk("clear_on_rise", head(), 32'h0);
        chk("flush_hold_strobe", 32'(mem_addr_strobe), 32'h1);
        chk("flush_hold_addr", 32'(mem_addr), 32'h412);
        budget = 1 << 30;
        step(6);
        chk("flush_restart_head", head(), 32'h500);
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vgahdmi_fetch_ctrl.md
Name: vgahdmi_fetch_ctrl

Overview:
- Frame-buffer fetch controller that feeds the 640x480 bit-plane video output.
- Reads 32-bit words from system memory over a strobe/ready read port and buffers them in a small show-ahead FIFO.
- Presents the head word as red/green/blue/bright bytes; each word covers 8 pixels.
- Pops one word per fetch_next pulse, restarts at base_addr on every vsync rising edge, and flags FIFO underflow.

Parameters:
- resolution_x, 640, active pixels per line.
- resolution_y, 480, active lines per frame.
- words_per_frame, resolution_x*resolution_y/8 (38400), words fetched per frame.
- fifo_depth_log2, 4, FIFO holds 2**fifo_depth_log2 words (16).
- addr_width, 30, word-address width.

Ports:
- clk_pixel  in  1  pixel clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- base_addr  in  addr_width  frame-buffer word address; sampled on vsync rise.
- vsync  in  1  vertical sync from display timing; active-high pulse.
- fetch_next  in  1  one-cycle pop request from display; current bytes consumed.
- red_byte  out  8  head word [7:0].
- green_byte  out  8  head word [15:8].
- blue_byte  out  8  head word [23:16].
- bright_byte  out  8  head word [31:24].
- mem_addr  out  addr_width  read word address.
- mem_addr_strobe  out  1  read request.
- mem_data_in  in  32  read data.
- mem_data_ready  in  1  read acknowledge; data valid this cycle.
- underflow  out  1  sticky: fetch_next seen with FIFO empty.
- frame_done  out  1  high once all words_per_frame words are requested and acked.

Behaviour:
- Reset: state IDLE, FIFO count 0, pointers 0, mem_addr_strobe 0, mem_addr 0, underflow 0, frame_done 0, vsync_d 0, all byte outputs 0.
- vsync_d is a registered copy of vsync; rise = vsync & ~vsync_d.
- States:
  - IDLE: no requests.
  - FETCH: requests are issued.
  - FLUSH: wait for the outstanding ack, discard its data, then restart.
- On rise, base_addr and words_per_frame are latched, in any state:
  - No request outstanding: FIFO cleared (count 0, pointers 0), mem_addr = latched base, remaining = words_per_frame, frame_done 0, go to FETCH next cycle.
  - Request outstanding (strobe high): go to FLUSH. Strobe and mem_addr are held until mem_data_ready; that data is not written. The FIFO is cleared on the rise cycle and the restart happens on the cycle after the ack.
- Request rule (FETCH): mem_addr_strobe is asserted when remaining > 0 and count < 2**fifo_depth_log2 (the one in-flight slot is counted as reserved).
  - At most one request outstanding.
  - mem_addr stable while strobe is high.
  - Strobe drops, or advances to the next address, only on the cycle after mem_data_ready is sampled high.
  - Back-to-back requests are allowed: strobe may stay high with mem_addr+1.
- On ack in FETCH: mem_data_in written at the write pointer, count +1, mem_addr +1 (wraps modulo 2**addr_width), remaining −1.
  - When remaining reaches 0: frame_done set, go to IDLE.
- FIFO is show-ahead: byte outputs = head word whenever count > 0, else 0.
  - Head is valid on the same edge as fetch_next, so the display shift register samples it directly.
  - Pop takes effect at that edge; the new head is visible on the next cycle.
- Simultaneous push and pop: both happen, count unchanged.
- Pop when count = 0: ignored, underflow set (sticky until reset), pointers unchanged.
- Rise coincident with fetch_next or ack: rise wins; the pop is ignored and the ack is handled per the FLUSH rule.
- fetch_next arriving in IDLE after frame_done with FIFO empty: counts as underflow.
- Pointers wrap modulo FIFO depth; count is fifo_depth_log2+1 bits wide.
- Latency:
  - rise to first strobe: 1 cycle.
  - ack to byte outputs valid (from empty): 1 cycle.

Test Plan:
- Reset, then vsync rise with base_addr=0x100, memory acking every cycle with data = address -> strobe 1 cycle after rise; addresses 0x100.. issued; strobe stops at count 16; red_byte=0x00, bright_byte=0x00 for word 0x100; next word gives red_byte=0x01.
- With FIFO full, pulse fetch_next every 8 cycles for 80 pulses -> words popped in address order 0x100..0x14F, no underflow, count stays 15–16.
- Memory ack delayed 3 cycles per request while a vsync rise lands mid-request -> strobe and address held until ack; acked word discarded; next strobe at latched base_addr; first head word = data at base.
- words_per_frame reduced to 20 -> exactly 20 acks, then frame_done=1 and strobe stays 0 until the next rise; frame_done clears on rise.
- fetch_next pulsed with FIFO empty after reset -> underflow=1, bytes remain 0; underflow stays 1 across a subsequent vsync rise; cleared only by reset.
- Push and pop in the same cycle at count=5 -> count stays 5; head advances by one word; new word is stored at the correct pointer, including across pointer wrap 15->0.
